// File: rtl/sub_serial_pkg.sv
// Shared definitions for the serial subtractor: default sizes, status-bus
// flag positions and the controller state encoding.
package sub_serial_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DIGIT_DEF = 4;

    localparam int unsigned FLAG_OF = 3;
    localparam int unsigned FLAG_CF = 2;
    localparam int unsigned FLAG_SF = 1;
    localparam int unsigned FLAG_ZF = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sub_digit.sv
// One DIGIT-bit slice of the borrow chain: d = x - y - bin, bout = borrow out.
module sub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] diff;

    // The extra top bit goes to 1 exactly when the slice borrows.
    assign diff = {1'b0, x} - {1'b0, y} - (DIGIT+1)'(bin);
    assign d    = diff[DIGIT-1:0];
    assign bout = diff[DIGIT];

endmodule

// File: rtl/sub_serial.sv
// Multi-cycle subtractor c = a - b, one DIGIT-bit slice per clock, LSB first,
// with start/busy/done handshake and OF/CF/SF/ZF flags.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             OF,
    output logic             CF,
    output logic             SF,
    output logic             ZF
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_msb;
    logic             b_msb;
    logic             borrow;
    logic             nz;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;

    logic [DIGIT-1:0] d;
    logic             bout;
    logic [WIDTH-1:0] res_next;

    // Operands shift right each cycle so the active digit is always the low slice.
    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    assign res_next = {d, res[WIDTH-1:DIGIT]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            borrow <= 1'b0;
            nz     <= 1'b0;
            res    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            c      <= '0;
            flags  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        a_q    <= a;
                        b_q    <= b;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        borrow <= 1'b0;
                        cnt    <= '0;
                        nz     <= 1'b0;
                    end
                end
                RUN: begin
                    a_q    <= a_q >> DIGIT;
                    b_q    <= b_q >> DIGIT;
                    borrow <= bout;
                    nz     <= nz | (|d);
                    res    <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        c              <= res_next;
                        flags[FLAG_CF] <= bout;
                        flags[FLAG_SF] <= d[DIGIT-1];
                        flags[FLAG_ZF] <= ~(nz | (|d));
                        flags[FLAG_OF] <= (a_msb != b_msb) && (d[DIGIT-1] != a_msb);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign OF = flags[FLAG_OF];
    assign CF = flags[FLAG_CF];
    assign SF = flags[FLAG_SF];
    assign ZF = flags[FLAG_ZF];

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial: directed vector table, random operands against a
// signed/unsigned arithmetic model, and handshake/reset corner sequences.
module tb_sub_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] c;
    logic        OF;
    logic        CF;
    logic        SF;
    logic        ZF;

    int tests;
    int fails;

    sub_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .c     (c),
        .OF    (OF),
        .CF    (CF),
        .SF    (SF),
        .ZF    (ZF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags from arithmetic meaning: overflow = true difference outside int32 range.
    function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb);
        longint s;
        logic [31:0] r;
        logic of, cf, sf, zf;
        s  = longint'($signed(ma)) - longint'($signed(mb));
        r  = ma - mb;
        of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        cf = (ma < mb);
        sf = ($signed(r) < 0);
        zf = (ma == mb);
        return {of, cf, sf, zf, r};
    endfunction

    // Accept on the next edge; returns cycles from acceptance until done is seen.
    task automatic launch(input logic [31:0] la, input logic [31:0] lb);
        @(negedge clk);
        a = la;
        b = lb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] la, input logic [31:0] lb,
                          input logic [31:0] ec, input logic [3:0] ef);
        int lat;
        launch(la, lb);
        check({name, " busy"}, 64'(busy), 64'd1);
        wait_done(0, lat);
        check({name, " latency"}, 64'(lat), 64'd8);
        check({name, " c"}, 64'(c), 64'(ec));
        check({name, " flags"}, 64'({OF, CF, SF, ZF}), 64'(ef));
        check({name, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb, held;
        logic [35:0] m;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;

        vecs[0] = '{32'd5,         32'd3,         32'h0000_0002, 4'b0000};
        vecs[1] = '{32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0110};
        vecs[2] = '{32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b1000};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1110};
        vecs[4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 4'b0001};
        vecs[5] = '{32'h0000_0010, 32'h0000_0000, 32'h0000_0010, 4'b0000};
        vecs[6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0110};

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 64'({busy, done, OF, CF, SF, ZF}), 64'd0);
        check("reset c", 64'(c), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].f);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : 32'($urandom);
            if (i % 5 == 1) rb = ra ^ 32'h8000_0000;
            m = model(ra, rb);
            run_op($sformatf("rand%0d", i), ra, rb, m[31:0], m[35:32]);
        end

        // start during RUN is ignored; outputs hold until completion
        held = c;
        launch(32'd9, 32'd4);
        lat = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold c mid-run", 64'(c), 64'(held));
        @(negedge clk);
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        check("busy during ignored start", 64'(busy), 64'd1);
        wait_done(lat, lat);
        check("ignored start latency", 64'(lat), 64'd8);
        check("ignored start c", 64'(c), 64'd5);

        // back-to-back: start in the done cycle
        a = 32'd7;
        b = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b done cleared", 64'(done), 64'd0);
        check("b2b busy", 64'(busy), 64'd1);
        check("b2b c held", 64'(c), 64'd5);
        wait_done(0, lat);
        check("b2b latency", 64'(lat), 64'd8);
        check("b2b c", 64'(c), 64'd5);

        // reset mid-operation aborts with no done
        launch(32'd100, 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort outputs", 64'({busy, done, OF, CF, SF, ZF}), 64'd0);
        check("abort c", 64'(c), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) lat++;
        end
        check("no done after abort", 64'(lat), 64'd0);
        run_op("after reset", 32'd100, 32'd1, 32'd99, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
